nios2_cpu_div_cell: RTL

//  Iterative radix-2 restoring divider; inverse counterpart of the CPU multiply cell.

---
 rtl/nios2_div_pkg.sv | 10 +
 rtl/nios2_div_step.sv | 17 +
 rtl/nios2_cpu_div_cell.sv | 102 ++++++++++
 3 files changed

// File: rtl/nios2_div_pkg.sv
// nios2_div_pkg: shared FSM state, default width and counter sizing for the divide cell
package nios2_div_pkg;
  localparam int DIV_WIDTH_DEFAULT = 32;
  typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} div_state_t;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/nios2_div_step.sv
// nios2_div_step: one combinational restoring-division step on magnitudes
module nios2_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] next_rem,
  output logic             q_bit
);
  logic [WIDTH:0] shifted, diff;
  // rem < dvs keeps the difference inside a signed WIDTH+1 range, so its MSB is the borrow
  assign shifted  = {rem, dvd_bit};
  assign diff     = shifted - {1'b0, dvs};
  assign q_bit    = ~diff[WIDTH];
  assign next_rem = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
endmodule

// File: rtl/nios2_cpu_div_cell.sv
// nios2_cpu_div_cell: iterative radix-2 restoring divider, signed/unsigned per operand.
// NIOS2_DIV_ZERO_DETECT_EN: short-circuit zero divisors and report div_by_zero.
module nios2_cpu_div_cell
  import nios2_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             src1_signed,
  input  logic             src2_signed,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = clog2(WIDTH);
  div_state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] a, b, dvd, dvs, rem, next_rem;
  logic s1s, s2s, q_neg, r_neg, dz, q_bit, a_neg, b_neg;
  assign a_neg = s1s & a[WIDTH-1];
  assign b_neg = s2s & b[WIDTH-1];
  nios2_div_step #(.WIDTH(WIDTH)) u_step (
    .rem(rem),
    .dvd_bit(dvd[WIDTH-1]),
    .dvs(dvs),
    .next_rem(next_rem),
    .q_bit(q_bit)
  );
  // dvd shifts dividend bits out of its MSB and quotient bits into its LSB
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      a            <= '0;
      b            <= '0;
      dvd          <= '0;
      dvs          <= '0;
      rem          <= '0;
      s1s          <= 1'b0;
      s2s          <= 1'b0;
      q_neg        <= 1'b0;
      r_neg        <= 1'b0;
      dz           <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      quotient     <= '0;
      remainder    <= '0;
      div_by_zero  <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: if (start) begin
          a     <= src1;
          b     <= src2;
          s1s   <= src1_signed;
          s2s   <= src2_signed;
          busy  <= 1'b1;
          state <= PREP;
        end
        PREP: begin
          dvd   <= a_neg ? -a : a;
          dvs   <= b_neg ? -b : b;
          rem   <= '0;
          cnt   <= '0;
          q_neg <= a_neg ^ b_neg;
          r_neg <= a_neg;
          dz    <= (b == '0);
`ifdef NIOS2_DIV_ZERO_DETECT_EN
          state <= (b == '0) ? FIX : ITER;
`else
          state <= ITER;
`endif
        end
        ITER: begin
          rem <= next_rem;
          dvd <= {dvd[WIDTH-2:0], q_bit};
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          quotient     <= dz ? '1 : q_neg ? -dvd : dvd;
          remainder    <= dz ? a : r_neg ? -rem : rem;
`ifdef NIOS2_DIV_ZERO_DETECT_EN
          div_by_zero  <= dz;
`else
          div_by_zero  <= 1'b0;
`endif
          result_valid <= 1'b1;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
